// File: rtl/fifo_uart_word_tx.sv
// Pops 32-bit words from a show-ahead FIFO and sends each one as four 8N1 UART
// bytes, with no idle gap between the bytes of a word.
module fifo_uart_word_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter bit MSB_BYTE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [31:0]       word_q;
  logic [6:0]        shift_q;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [1:0]        byte_idx;
  logic              bit_end;
  logic [7:0]        cur_byte;

  // Byte lane for the byte_idx-th byte on the wire.
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [1:0] lane;
    lane = MSB_BYTE_FIRST ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Reset gates the pop so a word is never lost while the block is held in reset.
  assign fifo_rd_en = !rst && (state == IDLE) && enable && !fifo_empty;
  assign bit_end    = (baud_cnt == BAUD_LAST);
  assign cur_byte   = pick_byte(word_q, byte_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      word_q    <= '0;
      shift_q   <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
      end
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            word_q   <= fifo_rd_data;
            byte_idx <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            // bit 0 goes straight to the line; shift_q keeps the remaining seven
            tx      <= cur_byte[0];
            shift_q <= cur_byte[7:1];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= shift_q[0];
              shift_q <= {1'b0, shift_q[6:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_idx == 2'd3) begin
              busy      <= 1'b0;
              word_done <= 1'b1;
              state     <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
